div: RTL and testbench

- Multi-cycle 32-bit signed/unsigned restoring divider serving the EX stage for DIV/DIVU.
- EX issues a start request and holds it. EX asserts a stall request to ctrl until the divider reports ready.
- The divider returns {remainder, quotient} for the HI/LO write that flows through the EX/MEM register.
- It is the responder side of the EX multi-cycle handshake that the EX/MEM register supports with its held-state feedback.

---
 rtl/div.sv | 102 ++++++++++
 tb/tb_div.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Multi-cycle 32-bit signed/unsigned restoring divider for DIV/DIVU in EX.
// One quotient bit per cycle; result {remainder, quotient} held while start_i stays high.
module div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dsr_q;
    logic        neg_quo;
    logic        neg_rem;

    logic        s1;
    logic        s2;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] partial;
    logic [32:0] diff;

    // Signed operands are reduced to magnitudes; the sign is restored at the end.
    assign s1   = signed_div_i & opdata1_i[31];
    assign s2   = signed_div_i & opdata2_i[31];
    assign mag1 = s1 ? (~opdata1_i + 32'd1) : opdata1_i;
    assign mag2 = s2 ? (~opdata2_i + 32'd1) : opdata2_i;

    // Next dividend bit shifts into the partial remainder, then trial-subtract.
    assign partial = {rem_q, quo_q[31]};
    assign diff    = partial - {1'b0, dsr_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FREE;
            cnt      <= 6'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dsr_q    <= 32'd0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state <= BY_ZERO;
                        end else begin
                            state   <= ON;
                            cnt     <= 6'd0;
                            rem_q   <= 32'd0;
                            quo_q   <= mag1;
                            dsr_q   <= mag2;
                            neg_quo <= s1 ^ s2;
                            neg_rem <= s1;
                        end
                    end
                end
                BY_ZERO: begin
                    state    <= END;
                    ready_o  <= 1'b1;
                    result_o <= 64'd0;
                end
                ON: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else if (cnt != 6'd32) begin
                        rem_q <= diff[32] ? partial[31:0] : diff[31:0];
                        quo_q <= {quo_q[30:0], ~diff[32]};
                        cnt   <= cnt + 6'd1;
                    end else begin
                        state    <= END;
                        ready_o  <= 1'b1;
                        result_o <= {neg_rem ? (~rem_q + 32'd1) : rem_q,
                                     neg_quo ? (~quo_q + 32'd1) : quo_q};
                    end
                end
                END: begin
                    if (!start_i || annul_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed vector table, random vectors against an
// arithmetic reference model, and hand sequences for annul, reset and hold.
module tb_div;

    logic        clk;
    logic        rst_n;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int tests;
    int fails;

    div dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [63:0] res;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division in 64-bit so the overflow case wraps.
    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input logic [63:0] exp_res,
                           input string nm, input int hold_extra);
        int lat;
        bit got;
        @(negedge clk);
        signed_div = sg; op1 = a; op2 = b; start = 1'b1;
        lat = 0; got = 0;
        while (!got && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (ready) got = 1;
        end
        chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_res"}, result, exp_res);
        for (int i = 0; i < hold_extra; i++) begin
            @(posedge clk); #1;
            chk({nm, "_hold_rdy"}, 64'(ready), 64'd1);
            chk({nm, "_hold_res"}, result, exp_res);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_drop_rdy"}, 64'(ready), 64'd0);
        chk({nm, "_drop_res"}, result, 64'd0);
    endtask

    initial begin
        int seen;
        logic        rs;
        logic [31:0] ra, rb;
        logic [63:0] er;
        tests = 0; fails = 0;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          34, {32'd2, 32'd14},                "u100_7"};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   34, {32'hFFFFFFFF, 32'hFFFFFFFD},   "s_m7_2"};
        vecs[2] = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   34, {32'h00000001, 32'hFFFFFFFD},   "s_7_m2"};
        vecs[3] = '{1'b0, 32'h12345678,   32'h00000000,   2,  64'd0,                          "by_zero"};
        vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   34, {32'h00000000, 32'h80000000},   "s_ovf"};
        vecs[5] = '{1'b0, 32'hFFFFFFFF,   32'h00000010,   34, {32'h0000000F, 32'h0FFFFFFF},   "u_ffff_16"};
        vecs[6] = '{1'b0, 32'hFFFFFFF9,   32'h00000002,   34, {32'h00000001, 32'h7FFFFFFC},   "u_big_2"};
        vecs[7] = '{1'b1, 32'h12345678,   32'h00000000,   2,  64'd0,                          "s_by_zero"};

        rst_n = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdy", 64'(ready), 64'd0);
        chk("reset_res", result, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i])
            run_div(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].res, vecs[i].name, 0);

        // Overflow case with start held: result must stay put, no restart.
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 34, {32'h0, 32'h80000000}, "s_ovf_hold", 5);

        // Annul at iteration 10, then a fresh divide.
        @(negedge clk); signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk); annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("annul_rdy", 64'(ready), 64'd0);
        @(negedge clk); annul = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        chk("annul_no_result", 64'(seen), 64'd0);
        run_div(1'b0, 32'hFFFFFFFF, 32'h10, 34, {32'hF, 32'h0FFFFFFF}, "after_annul", 0);

        // Annul together with start in FREE blocks the start.
        @(negedge clk); op1 = 32'd50; op2 = 32'd5; start = 1'b1; annul = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0; annul = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        chk("annul_free_block", 64'(seen), 64'd0);

        // Annul in END with start still held returns to FREE.
        @(negedge clk); signed_div = 1'b0; op1 = 32'd20; op2 = 32'd3; start = 1'b1;
        seen = 0;
        for (int i = 0; i < 100 && !ready; i++) begin
            @(posedge clk); #1;
        end
        chk("end_annul_pre", {63'd0, ready}, 64'd1);
        @(negedge clk); annul = 1'b1;
        @(posedge clk); #1;
        chk("end_annul_rdy", 64'(ready), 64'd0);
        @(negedge clk); annul = 1'b0; start = 1'b0;
        @(posedge clk);

        // Async reset mid-ON.
        @(negedge clk); op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (6) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        chk("rst_on_rdy", 64'(ready), 64'd0);
        chk("rst_on_res", result, 64'd0);
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run_div(1'b0, 32'd9, 32'd3, 34, {32'd0, 32'd3}, "after_rst", 0);

        // Async reset while a result is being presented.
        @(negedge clk); op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        for (int i = 0; i < 100 && !ready; i++) begin
            @(posedge clk); #1;
        end
        chk("rst_end_pre", {63'd0, ready}, 64'd1);
        #3; rst_n = 1'b0; #1;
        chk("rst_end_rdy", 64'(ready), 64'd0);
        chk("rst_end_res", result, 64'd0);
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Randomized vectors against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1, 2: rb = 32'($urandom_range(1, 15));
                3: rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            er = model(rs, ra, rb);
            run_div(rs, ra, rb, (rb == 32'd0) ? 2 : 34, er, $sformatf("rnd%0d", i), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
